// File: rtl/ntsc_osd_pkg.sv
// Shared definitions for the NTSC OSD text path: control codes, printable range,
// VRAM geometry and the console writer state encoding.
package ntsc_osd_pkg;

  localparam int VRAM_COLS = 32;
  localparam int VRAM_ROWS = 32;
  localparam int VRAM_AW   = 10;
  localparam int COL_W     = $clog2(VRAM_COLS);
  localparam int ROW_W     = $clog2(VRAM_ROWS);

  localparam logic [7:0] CC_BS = 8'h08;
  localparam logic [7:0] CC_LF = 8'h0A;
  localparam logic [7:0] CC_FF = 8'h0C;
  localparam logic [7:0] CC_CR = 8'h0D;

  localparam logic [7:0] PRINT_MIN = 8'h20;
  localparam logic [7:0] PRINT_MAX = 8'h7E;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLR_LINE = 2'd1,
    CLR_ALL  = 2'd2
  } state_e;

  function automatic logic is_printable(input logic [7:0] code);
    return (code >= PRINT_MIN) && (code <= PRINT_MAX);
  endfunction

endpackage

// File: rtl/vram_clear_seq.sv
// Counter-based blank-fill address sequencer, shared by the single-row and
// whole-screen clear states. Reset leaves it armed for a whole-screen clear.
module vram_clear_seq
  import ntsc_osd_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               ce,
  input  logic               start,
  input  logic               all_mode,
  input  logic               step,
  input  logic [ROW_W-1:0]   row,
  output logic [VRAM_AW-1:0] addr,
  output logic               last
);

  logic [VRAM_AW-1:0] cnt_r;
  logic               all_r;
  logic [ROW_W-1:0]   row_r;

  // Load on start, advance one cell per issued clear write
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {VRAM_AW{1'b0}};
      all_r <= 1'b1;
      row_r <= {ROW_W{1'b0}};
    end else if (ce) begin
      if (start) begin
        cnt_r <= {VRAM_AW{1'b0}};
        all_r <= all_mode;
        row_r <= row;
      end else if (step) begin
        cnt_r <= cnt_r + VRAM_AW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign addr = all_r ? cnt_r : {row_r, cnt_r[COL_W-1:0]};
  assign last = all_r ? (cnt_r == {VRAM_AW{1'b1}})
                      : (cnt_r[COL_W-1:0] == {COL_W{1'b1}});

endmodule

// File: rtl/vram_console_writer.sv
// Text-console front end: turns an ASCII byte stream into character generator
// VRAM writes, tracking the cursor, clearing lines and scrolling the view.
module vram_console_writer
  import ntsc_osd_pkg::*;
#(
  parameter int         C_VIS_ROWS = 24,
  parameter logic [7:0] C_BLANK    = 8'h20
)
(
  input  logic               CK_i,
  input  logic               RST_i,
  input  logic               CK_EE_i,
  input  logic [7:0]         DATs_i,
  input  logic               VALID_i,
  output logic               READY_o,
  output logic [7:0]         VRAM_WDs_o,
  output logic [VRAM_AW-1:0] VRAM_WAs_o,
  output logic               VRAM_WE_o,
  output logic [7:0]         V_SCROLLs_o,
  output logic [4:0]         CUR_COLs_o,
  output logic [4:0]         CUR_ROWs_o,
  output logic               BUSY_o
);

  // A view of 32 rows truncates to 0: scroll once the cursor laps the top row
  localparam logic [ROW_W-1:0] VIS_MOD = ROW_W'(C_VIS_ROWS);

  state_e             state_r, state_s;
  logic [COL_W-1:0]   col_r, col_s;
  logic [ROW_W-1:0]   row_r, row_s;
  logic [ROW_W-1:0]   top_r, top_s;
  logic               pend_r, pend_s;
  logic               we_r, we_s;
  logic [VRAM_AW-1:0] wa_r, wa_s;
  logic [7:0]         wd_r, wd_s;

  logic               nl_s;
  logic [ROW_W-1:0]   row_inc_s;
  logic [ROW_W-1:0]   diff_s;
  logic               seq_start_s;
  logic               seq_all_s;
  logic               seq_step_s;
  logic [ROW_W-1:0]   seq_row_s;
  logic [VRAM_AW-1:0] seq_addr_s;
  logic               seq_last_s;

  assign row_inc_s = row_r + ROW_W'(1);
  assign diff_s    = row_inc_s - top_r;

  vram_clear_seq u_clear_seq (
    .clk      (CK_i),
    .rst      (RST_i),
    .ce       (CK_EE_i),
    .start    (seq_start_s),
    .all_mode (seq_all_s),
    .step     (seq_step_s),
    .row      (seq_row_s),
    .addr     (seq_addr_s),
    .last     (seq_last_s)
  );

  // Next-state, cursor and write-port decode
  always_comb begin
    state_s     = state_r;
    col_s       = col_r;
    row_s       = row_r;
    top_s       = top_r;
    pend_s      = pend_r;
    we_s        = 1'b0;
    wa_s        = wa_r;
    wd_s        = wd_r;
    seq_start_s = 1'b0;
    seq_all_s   = 1'b0;
    seq_step_s  = 1'b0;
    nl_s        = 1'b0;

    case (state_r)
      IDLE: begin
        if (VALID_i) begin
          if (is_printable(DATs_i)) begin
            we_s = 1'b1;
            wa_s = {row_r, col_r};
            wd_s = DATs_i;
            if (col_r == {COL_W{1'b1}}) begin
              col_s = {COL_W{1'b0}};
              nl_s  = 1'b1;
            end else begin
              col_s = col_r + COL_W'(1);
            end
          end else if (DATs_i == CC_CR) begin
            col_s = {COL_W{1'b0}};
          end else if (DATs_i == CC_LF) begin
            nl_s = 1'b1;
          end else if (DATs_i == CC_BS) begin
            if (col_r != {COL_W{1'b0}}) begin
              col_s = col_r - COL_W'(1);
            end else begin
              col_s = col_r;
            end
          end else if (DATs_i == CC_FF) begin
            state_s     = CLR_ALL;
            seq_start_s = 1'b1;
            seq_all_s   = 1'b1;
            col_s       = {COL_W{1'b0}};
            row_s       = {ROW_W{1'b0}};
            top_s       = {ROW_W{1'b0}};
            pend_s      = 1'b0;
          end else begin
            col_s = col_r;
          end
        end else begin
          state_s = IDLE;
        end
      end
      CLR_LINE, CLR_ALL: begin
        seq_step_s = 1'b1;
        we_s       = 1'b1;
        wa_s       = seq_addr_s;
        wd_s       = C_BLANK;
        if (seq_last_s) begin
          state_s = IDLE;
          // The view scrolls together with the final blank of the new line
          if (pend_r) begin
            top_s  = top_r + ROW_W'(1);
            pend_s = 1'b0;
          end else begin
            top_s = top_r;
          end
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s     = CLR_ALL;
        seq_start_s = 1'b1;
        seq_all_s   = 1'b1;
      end
    endcase

    if (nl_s) begin
      row_s       = row_inc_s;
      pend_s      = (diff_s == VIS_MOD);
      state_s     = CLR_LINE;
      seq_start_s = 1'b1;
      seq_all_s   = 1'b0;
      seq_row_s   = row_inc_s;
    end else begin
      seq_row_s   = row_r;
    end
  end

  // State and output registers; reset forces a full-screen clear
  always_ff @(posedge CK_i) begin
    if (RST_i) begin
      state_r <= CLR_ALL;
      col_r   <= {COL_W{1'b0}};
      row_r   <= {ROW_W{1'b0}};
      top_r   <= {ROW_W{1'b0}};
      pend_r  <= 1'b0;
      we_r    <= 1'b0;
      wa_r    <= {VRAM_AW{1'b0}};
      wd_r    <= C_BLANK;
    end else if (CK_EE_i) begin
      state_r <= state_s;
      col_r   <= col_s;
      row_r   <= row_s;
      top_r   <= top_s;
      pend_r  <= pend_s;
      we_r    <= we_s;
      wa_r    <= wa_s;
      wd_r    <= wd_s;
    end else begin
      state_r <= state_r;
    end
  end

  assign READY_o     = (state_r == IDLE);
  assign BUSY_o      = (state_r != IDLE);
  assign VRAM_WE_o   = we_r;
  assign VRAM_WAs_o  = wa_r;
  assign VRAM_WDs_o  = wd_r;
  assign V_SCROLLs_o = {top_r, 3'b000};
  assign CUR_COLs_o  = col_r;
  assign CUR_ROWs_o  = row_r;

endmodule

// File: tb/tb_vram_console_writer.sv
// Self-checking bench for vram_console_writer: a reference model queues every
// expected VRAM write, and a monitor compares them as the DUT issues writes.
module tb_vram_console_writer;

  localparam int VIS = 24;

  logic       CK_i    = 1'b0;
  logic       RST_i   = 1'b1;
  logic       CK_EE_i = 1'b0;
  logic [7:0] DATs_i  = 8'h00;
  logic       VALID_i = 1'b0;
  logic       READY_o;
  logic [7:0] VRAM_WDs_o;
  logic [9:0] VRAM_WAs_o;
  logic       VRAM_WE_o;
  logic [7:0] V_SCROLLs_o;
  logic [4:0] CUR_COLs_o;
  logic [4:0] CUR_ROWs_o;
  logic       BUSY_o;

  vram_console_writer #(.C_VIS_ROWS(VIS), .C_BLANK(8'h20)) dut (
    .CK_i        (CK_i),
    .RST_i       (RST_i),
    .CK_EE_i     (CK_EE_i),
    .DATs_i      (DATs_i),
    .VALID_i     (VALID_i),
    .READY_o     (READY_o),
    .VRAM_WDs_o  (VRAM_WDs_o),
    .VRAM_WAs_o  (VRAM_WAs_o),
    .VRAM_WE_o   (VRAM_WE_o),
    .V_SCROLLs_o (V_SCROLLs_o),
    .CUR_COLs_o  (CUR_COLs_o),
    .CUR_ROWs_o  (CUR_ROWs_o),
    .BUSY_o      (BUSY_o)
  );

  always #5 CK_i = ~CK_i;

  typedef struct {
    logic [9:0] addr;
    logic [7:0] data;
    logic       ready;
    logic [7:0] vs;
  } wr_t;

  typedef struct {
    logic [7:0] code;
    logic [4:0] col;
    logic [4:0] row;
  } vec_t;

  wr_t  sb[$];
  int   checks = 0;
  int   errors = 0;
  int   writes_seen = 0;
  int   ce_div = 0;
  logic ce_seen = 1'b0;
  logic rst_seen = 1'b1;
  logic [4:0] m_col, m_row, m_top;

  // clock enable every 4th clock, changed on the falling edge
  initial forever begin
    @(negedge CK_i);
    ce_div  = (ce_div + 1) % 4;
    CK_EE_i = (ce_div == 0);
  end

  initial forever begin
    @(posedge CK_i);
    ce_seen  = CK_EE_i;
    rst_seen = RST_i;
  end

  // write monitor: one check per enabled, non-reset edge showing a write
  initial forever begin
    wr_t e;
    @(negedge CK_i);
    if (ce_seen && !rst_seen && VRAM_WE_o !== 1'b0) begin
      writes_seen++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got addr=%h data=%h, required no write", VRAM_WAs_o, VRAM_WDs_o);
      end else begin
        e = sb.pop_front();
        if ({VRAM_WAs_o, VRAM_WDs_o, READY_o, BUSY_o, V_SCROLLs_o} !==
            {e.addr, e.data, e.ready, ~e.ready, e.vs}) begin
          errors++;
          $display("FAIL wr_check #%0d: got addr=%h data=%h rdy=%b busy=%b vs=%h, required addr=%h data=%h rdy=%b busy=%b vs=%h",
                   writes_seen, VRAM_WAs_o, VRAM_WDs_o, READY_o, BUSY_o, V_SCROLLs_o,
                   e.addr, e.data, e.ready, ~e.ready, e.vs);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [9:0] a, input logic [7:0] d, input logic r, input logic [7:0] v);
    wr_t e;
    e.addr = a; e.data = d; e.ready = r; e.vs = v;
    sb.push_back(e);
  endtask

  task automatic push_clear_all();
    for (int i = 0; i < 1024; i++) push_wr(10'(i), 8'h20, (i == 1023), 8'h00);
  endtask

  task automatic model_newline();
    logic [4:0] r;
    logic       sc;
    r  = m_row + 5'd1;
    sc = ((r - m_top) == 5'(VIS));
    m_row = r;
    for (int i = 0; i < 32; i++)
      push_wr({r, 5'(i)}, 8'h20, (i == 31),
              (sc && i == 31) ? {m_top + 5'd1, 3'b000} : {m_top, 3'b000});
    if (sc) m_top = m_top + 5'd1;
  endtask

  task automatic model_accept(input logic [7:0] c);
    if (c >= 8'h20 && c <= 8'h7E) begin
      push_wr({m_row, m_col}, c, (m_col != 5'd31), {m_top, 3'b000});
      if (m_col == 5'd31) begin
        m_col = 5'd0;
        model_newline();
      end else begin
        m_col = m_col + 5'd1;
      end
    end else if (c == 8'h0D) begin
      m_col = 5'd0;
    end else if (c == 8'h0A) begin
      model_newline();
    end else if (c == 8'h08) begin
      if (m_col != 5'd0) m_col = m_col - 5'd1;
    end else if (c == 8'h0C) begin
      m_col = 5'd0; m_row = 5'd0; m_top = 5'd0;
      push_clear_all();
    end
  endtask

  task automatic send(input logic [7:0] c);
    int n;
    model_accept(c);
    DATs_i  = c;
    VALID_i = 1'b1;
    n = 0;
    do begin
      @(negedge CK_i); #1;
      n++;
    end while (!(CK_EE_i && READY_o) && n < 8000);
    checks++;
    if (!(CK_EE_i && READY_o)) begin
      errors++;
      $display("FAIL send_timeout: code %h not accepted, ready=%b", c, READY_o);
      VALID_i = 1'b0;
    end else begin
      @(posedge CK_i); #1;
      VALID_i = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge CK_i); #1;
      n++;
    end while (!(sb.size() == 0 && READY_o === 1'b1) && n < 8000);
    checks++;
    if (!(sb.size() == 0 && READY_o === 1'b1)) begin
      errors++;
      $display("FAIL %s_idle: got pending=%0d ready=%b, required pending=0 ready=1", name, sb.size(), READY_o);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 32'(READY_o),     32'd0);
    chk({tag, "_busy"},  32'(BUSY_o),      32'd1);
    chk({tag, "_we"},    32'(VRAM_WE_o),   32'd0);
    chk({tag, "_wa"},    32'(VRAM_WAs_o),  32'd0);
    chk({tag, "_wd"},    32'(VRAM_WDs_o),  32'h20);
    chk({tag, "_vs"},    32'(V_SCROLLs_o), 32'd0);
    chk({tag, "_col"},   32'(CUR_COLs_o),  32'd0);
    chk({tag, "_row"},   32'(CUR_ROWs_o),  32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[12];
    int   base, n;

    vt[0]  = '{8'h41, 5'd1, 5'd0};
    vt[1]  = '{8'h42, 5'd2, 5'd0};
    vt[2]  = '{8'h08, 5'd1, 5'd0};
    vt[3]  = '{8'h07, 5'd1, 5'd0};
    vt[4]  = '{8'h0D, 5'd0, 5'd0};
    vt[5]  = '{8'h08, 5'd0, 5'd0};
    vt[6]  = '{8'h7E, 5'd1, 5'd0};
    vt[7]  = '{8'h0A, 5'd1, 5'd1};
    vt[8]  = '{8'h7F, 5'd1, 5'd1};
    vt[9]  = '{8'h1F, 5'd1, 5'd1};
    vt[10] = '{8'h20, 5'd2, 5'd1};
    vt[11] = '{8'h0D, 5'd0, 5'd1};

    // power-on reset and the mandatory full-screen blank
    m_col = 5'd0; m_row = 5'd0; m_top = 5'd0;
    push_clear_all();
    repeat (3) @(negedge CK_i);
    #1;
    chk_reset("rst");
    RST_i = 1'b0;
    wait_idle("init");
    chk("init_busy", 32'(BUSY_o), 32'd0);
    chk("init_vs", 32'(V_SCROLLs_o), 32'd0);

    // table: characters and control codes, cursor checked after each accept
    for (int i = 0; i < 12; i++) begin
      send(vt[i].code);
      chk($sformatf("vec%0d_col", i), 32'(CUR_COLs_o), 32'(vt[i].col));
      chk($sformatf("vec%0d_row", i), 32'(CUR_ROWs_o), 32'(vt[i].row));
    end
    wait_idle("vec");
    chk("vec_vs", 32'(V_SCROLLs_o), 32'd0);

    // form feed, then a full line of printables forcing a wrap
    send(8'h0C);
    wait_idle("ff1");
    chk("ff1_col", 32'(CUR_COLs_o), 32'd0);
    chk("ff1_row", 32'(CUR_ROWs_o), 32'd0);
    for (int i = 0; i < 32; i++) send(8'h30 + 8'(i));
    wait_idle("wrap");
    chk("wrap_col", 32'(CUR_COLs_o), 32'd0);
    chk("wrap_row", 32'(CUR_ROWs_o), 32'd1);

    // scroll once the new line reaches the bottom of the visible window
    send(8'h0C);
    wait_idle("ff2");
    for (int k = 1; k <= 24; k++) begin
      send(8'h0A);
      if (k == 23) begin
        wait_idle("lf23");
        chk("lf23_vs", 32'(V_SCROLLs_o), 32'd0);
      end
    end
    wait_idle("lf24");
    chk("lf24_vs",  32'(V_SCROLLs_o), 32'h08);
    chk("lf24_row", 32'(CUR_ROWs_o),  32'd24);
    chk("lf24_col", 32'(CUR_COLs_o),  32'd0);

    // reset in the middle of a line clear
    base = writes_seen;
    send(8'h0A);
    n = 0;
    while (writes_seen < base + 10 && n < 2000) begin
      @(negedge CK_i); #1;
      n++;
    end
    chk("midclr_writes", 32'(writes_seen - base), 32'd10);
    RST_i = 1'b1;
    sb.delete();
    m_col = 5'd0; m_row = 5'd0; m_top = 5'd0;
    push_clear_all();
    @(negedge CK_i); #1;
    chk_reset("rst2");
    @(negedge CK_i); #1;
    RST_i = 1'b0;
    wait_idle("rst2");
    chk("rst2_col",  32'(CUR_COLs_o),  32'd0);
    chk("rst2_row",  32'(CUR_ROWs_o),  32'd0);
    chk("rst2_vs",   32'(V_SCROLLs_o), 32'd0);
    chk("rst2_busy", 32'(BUSY_o),      32'd0);
    chk("sb_empty",  32'(sb.size()),   32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
